// File: rtl/mov_sprite_ctrl_pkg.sv
// Shared types and helpers for the moving-sprite scheduler.
package mov_sprite_pkg;

  localparam int SPR_DIM     = 16;
  localparam int OFF_W       = 4;
  localparam int SEL_W       = 6;
  localparam int PIX_W       = 2;
  localparam int SPR_COORD_W = 10;
  localparam int SPR_SLOTS   = 8;
  localparam int SPR_SLOT_W  = $clog2(SPR_SLOTS);

  localparam logic [PIX_W-1:0] TRANSPARENT = 2'b00;

  typedef struct packed {
    logic                   en;
    logic [SPR_COORD_W-1:0] x;
    logic [SPR_COORD_W-1:0] y;
    logic [SEL_W-1:0]       sel;
  } spr_ent_t;

  // Lowest set bit wins: slot 0 has the highest priority.
  function automatic logic [SPR_SLOT_W-1:0] prio_enc(input logic [SPR_SLOTS-1:0] v);
    logic [SPR_SLOT_W-1:0] r;
    r = '0;
    for (int i = SPR_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) r = SPR_SLOT_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mov_sprite_ctrl_if.sv
// Config, pixel, memory and mixer signals of the sprite scheduler.
// Collision outputs exist only when MOV_SPRITE_COLLISION_EN is defined.
interface mov_sprite_ctrl_if #(
  parameter int NUM_SPRITES = 8,
  parameter int COORD_W     = 10
);
  localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic               frame_start;
  logic               cfg_wr;
  logic [SLOT_W-1:0]  cfg_idx;
  logic [COORD_W-1:0] cfg_x;
  logic [COORD_W-1:0] cfg_y;
  logic [5:0]         cfg_sel;
  logic               cfg_en;
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  logic               px_valid;
  logic [5:0]         mem_select;
  logic [3:0]         mem_x;
  logic [3:0]         mem_y;
  logic [1:0]         mem_pix;
  logic               mem_en;
  logic [1:0]         pix_out;
  logic               pix_valid;
  logic [SLOT_W-1:0]  busy_slot;
`ifdef MOV_SPRITE_COLLISION_EN
  logic                   collision;
  logic [NUM_SPRITES-1:0] collision_mask;
`endif

  modport master (
    output frame_start, cfg_wr, cfg_idx, cfg_x, cfg_y, cfg_sel, cfg_en,
    output px, py, px_valid, mem_pix, mem_en,
    input  mem_select, mem_x, mem_y, pix_out, pix_valid, busy_slot
`ifdef MOV_SPRITE_COLLISION_EN
    , input collision, collision_mask
`endif
  );

  modport slave (
    input  frame_start, cfg_wr, cfg_idx, cfg_x, cfg_y, cfg_sel, cfg_en,
    input  px, py, px_valid, mem_pix, mem_en,
    output mem_select, mem_x, mem_y, pix_out, pix_valid, busy_slot
`ifdef MOV_SPRITE_COLLISION_EN
    , output collision, collision_mask
`endif
  );

endinterface

// File: rtl/mov_sprite_hit.sv
// Per-slot bounding-box test and pattern-local offset (combinational).
module mov_sprite_hit
  import mov_sprite_pkg::*;
#(
  parameter int COORD_W = SPR_COORD_W
) (
  input  spr_ent_t           ent,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               hit,
  output logic [OFF_W-1:0]   off_x,
  output logic [OFF_W-1:0]   off_y
);

  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;

  // One extra bit keeps the sign, so pixels left of/above the sprite miss.
  assign dx = {1'b0, px} - {1'b0, ent.x};
  assign dy = {1'b0, py} - {1'b0, ent.y};

  assign hit = ent.en
             && !dx[COORD_W] && (dx[COORD_W-1:OFF_W] == '0)
             && !dy[COORD_W] && (dy[COORD_W-1:OFF_W] == '0);

  assign off_x = dx[OFF_W-1:0];
  assign off_y = dy[OFF_W-1:0];

endmodule

// File: rtl/mov_sprite_ctrl.sv
// Sprite scheduler: shadowed slot table, priority hit test, 3-edge pixel pipeline.
// Optional sticky collision detect under MOV_SPRITE_COLLISION_EN.
module mov_sprite_ctrl
  import mov_sprite_pkg::*;
#(
  parameter int NUM_SPRITES = SPR_SLOTS,
  parameter int COORD_W     = SPR_COORD_W
) (
  input logic           clock,
  input logic           reset_n,
  mov_sprite_ctrl_if.slave bus
);

  localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  spr_ent_t               wr_ent;
  spr_ent_t               act [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit_vec;
  logic [OFF_W-1:0]       off_x [NUM_SPRITES];
  logic [OFF_W-1:0]       off_y [NUM_SPRITES];

  assign wr_ent = '{en: bus.cfg_en, x: bus.cfg_x, y: bus.cfg_y, sel: bus.cfg_sel};

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
    spr_ent_t shadow_q;
    spr_ent_t active_q;
    logic     wr_hit;

    // Out-of-range indices never match a slot and are dropped.
    assign wr_hit = bus.cfg_wr && (bus.cfg_idx == SLOT_W'(i));

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        if (wr_hit) shadow_q <= wr_ent;
        if (bus.frame_start) active_q <= wr_hit ? wr_ent : shadow_q;
      end
    end

    assign act[i] = active_q;

    mov_sprite_hit #(.COORD_W(COORD_W)) u_hit (
      .ent   (active_q),
      .px    (bus.px),
      .py    (bus.py),
      .hit   (hit_vec[i]),
      .off_x (off_x[i]),
      .off_y (off_y[i])
    );
  end

  logic [SLOT_W-1:0] win;
  logic              any_hit;

  assign win     = prio_enc(hit_vec);
  assign any_hit = |hit_vec;

  logic [SEL_W-1:0]  sel_q;
  logic [OFF_W-1:0]  mx_q;
  logic [OFF_W-1:0]  my_q;
  logic              h1_q, h2_q;
  logic [SLOT_W-1:0] slot1_q, slot2_q;
  logic [PIX_W-1:0]  pix_q;
  logic              pix_vld_q;
  logic [SLOT_W-1:0] busy_q;

  // Stage 1: address lines hold on a miss; only the hit flag drops.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sel_q   <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      h1_q    <= 1'b0;
      slot1_q <= '0;
    end else begin
      h1_q <= bus.px_valid && any_hit;
      if (bus.px_valid && any_hit) begin
        sel_q   <= act[win].sel;
        mx_q    <= off_x[win];
        my_q    <= off_y[win];
        slot1_q <= win;
      end
    end
  end

  // Stage 2 tracks the memory's address register; stage 3 gates the pixel.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      h2_q      <= 1'b0;
      slot2_q   <= '0;
      pix_q     <= '0;
      pix_vld_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      h2_q    <= h1_q;
      slot2_q <= slot1_q;
      if (h2_q && bus.mem_en && (bus.mem_pix != TRANSPARENT)) begin
        pix_q     <= bus.mem_pix;
        pix_vld_q <= 1'b1;
        busy_q    <= slot2_q;
      end else begin
        pix_q     <= '0;
        pix_vld_q <= 1'b0;
      end
    end
  end

  assign bus.mem_select = sel_q;
  assign bus.mem_x      = mx_q;
  assign bus.mem_y      = my_q;
  assign bus.pix_out    = pix_q;
  assign bus.pix_valid  = pix_vld_q;
  assign bus.busy_slot  = busy_q;

`ifdef MOV_SPRITE_COLLISION_EN
  logic                   coll_q;
  logic [NUM_SPRITES-1:0] coll_mask_q;
  logic                   multi_hit;

  assign multi_hit = (hit_vec & (hit_vec - NUM_SPRITES'(1))) != '0;

  // Frame start clears even when a collision is seen in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      coll_q      <= 1'b0;
      coll_mask_q <= '0;
    end else if (bus.frame_start) begin
      coll_q      <= 1'b0;
      coll_mask_q <= '0;
    end else if (bus.px_valid && multi_hit) begin
      coll_q      <= 1'b1;
      coll_mask_q <= coll_mask_q | hit_vec;
    end
  end

  assign bus.collision      = coll_q;
  assign bus.collision_mask = coll_mask_q;
`endif

endmodule

// File: tb/tb_mov_sprite_ctrl.sv
// Directed bench for mov_sprite_ctrl: vector table plus multi-cycle sequences.
module tb_mov_sprite_ctrl;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  mov_sprite_ctrl_if #(.NUM_SPRITES(8), .COORD_W(10)) bus ();

  mov_sprite_ctrl #(.NUM_SPRITES(8), .COORD_W(10)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Pattern memory: sel 5 fully clear, sel 6 shows column[1:0], else odd->2, even->1.
  function automatic logic [1:0] pat(input logic [5:0] sel, input logic [3:0] x);
    if (sel == 6'd5) return 2'b00;
    if (sel == 6'd6) return x[1:0];
    return sel[0] ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clock) bus.mem_pix <= pat(bus.mem_select, bus.mem_x);

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       vld;
    logic [1:0] pix;
    logic [2:0] slot;
    logic       chk_addr;
    logic [5:0] sel;
    logic [3:0] mx;
    logic [3:0] my;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                           input logic [5:0] sel, input logic en, input logic with_commit);
    bus.cfg_wr = 1'b1; bus.cfg_idx = idx; bus.cfg_x = x; bus.cfg_y = y;
    bus.cfg_sel = sel; bus.cfg_en = en; bus.frame_start = with_commit;
    tick();
    bus.cfg_wr = 1'b0; bus.frame_start = 1'b0;
  endtask

  task automatic commit();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  function automatic vec_t mk(input int px, input int py, input logic vld, input logic [1:0] pix,
                              input int slot, input logic chk, input int sel, input int mx, input int my);
    vec_t v;
    v.px = 10'(px); v.py = 10'(py); v.vld = vld; v.pix = pix; v.slot = 3'(slot);
    v.chk_addr = chk; v.sel = 6'(sel); v.mx = 4'(mx); v.my = 4'(my);
    return v;
  endfunction

  // One isolated pixel: address checked after the first edge, output after the third.
  task automatic run_vec(input vec_t v, input string tag);
    bus.px = v.px; bus.py = v.py; bus.px_valid = 1'b1;
    tick();
    bus.px_valid = 1'b0;
    if (v.chk_addr) begin
      check({tag, ".mem_select"}, 32'(bus.mem_select), 32'(v.sel));
      check({tag, ".mem_x"}, 32'(bus.mem_x), 32'(v.mx));
      check({tag, ".mem_y"}, 32'(bus.mem_y), 32'(v.my));
    end
    tick();
    tick();
    check({tag, ".pix_valid"}, 32'(bus.pix_valid), 32'(v.vld));
    check({tag, ".pix_out"}, 32'(bus.pix_out), 32'(v.pix));
    if (v.vld) check({tag, ".busy_slot"}, 32'(bus.busy_slot), 32'(v.slot));
  endtask

  initial begin
    vt[0]  = mk(105,  53, 1, 2'b10, 0, 1, 1,  5,  3);
    vt[1]  = mk(110,  52, 1, 2'b10, 0, 1, 1, 10,  2);
    vt[2]  = mk( 99,  53, 0, 2'b00, 0, 0, 0,  0,  0);
    vt[3]  = mk(115,  50, 1, 2'b10, 0, 1, 1, 15,  0);
    vt[4]  = mk(116,  50, 1, 2'b01, 3, 1, 2,  8,  0);
    vt[5]  = mk(105,  66, 0, 2'b00, 0, 0, 0,  0,  0);
    vt[6]  = mk(105,  65, 1, 2'b10, 0, 1, 1,  5, 15);
    vt[7]  = mk(  0,   0, 0, 2'b00, 0, 1, 6,  0,  0);
    vt[8]  = mk(  3,  15, 1, 2'b11, 5, 1, 6,  3, 15);
    vt[9]  = mk(305, 305, 0, 2'b00, 0, 1, 5,  5,  5);
    vt[10] = mk(1023, 1023, 0, 2'b00, 0, 0, 0, 0, 0);

    bus.frame_start = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_idx = '0;
    bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_sel = '0; bus.cfg_en = 1'b0;
    bus.mem_en = 1'b1;
    bus.px = 10'd105; bus.py = 10'd53; bus.px_valid = 1'b1;

    // Reset held with active video.
    reset_n = 1'b0;
    tick();
    tick();
    check("rst.pix_valid", 32'(bus.pix_valid), 32'd0);
    check("rst.pix_out", 32'(bus.pix_out), 32'd0);
    check("rst.mem_select", 32'(bus.mem_select), 32'd0);
    check("rst.mem_x", 32'(bus.mem_x), 32'd0);
    check("rst.busy_slot", 32'(bus.busy_slot), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst.pix_valid", 32'(bus.pix_valid), 32'd0);
    end
    bus.px_valid = 1'b0;
    tick(); tick(); tick();

    // Table load; nothing visible before the frame commit.
    cfg_write(3'd0, 10'd100, 10'd50, 6'd1, 1'b1, 1'b0);
    cfg_write(3'd3, 10'd108, 10'd50, 6'd2, 1'b1, 1'b0);
    cfg_write(3'd5, 10'd0,   10'd0,  6'd6, 1'b1, 1'b0);
    cfg_write(3'd6, 10'd300, 10'd300, 6'd5, 1'b1, 1'b0);
    run_vec(vt[2], "shadow_precommit");
    run_vec(mk(105, 53, 0, 2'b00, 0, 0, 0, 0, 0), "shadow_hidden");
    commit();

    for (int i = 0; i < 11; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Memory reports select out of range.
    bus.mem_en = 1'b0;
    run_vec(mk(105, 53, 0, 2'b00, 0, 1, 1, 5, 3), "mem_en_off");
    bus.mem_en = 1'b1;

    // Back-to-back pixels: one per cycle, each result three edges later.
    for (int j = 0; j < 7; j++) begin
      int idx[4] = '{0, 4, 8, 2};
      if (j >= 3) begin
        check($sformatf("tput%0d.pix_valid", j - 3), 32'(bus.pix_valid), 32'(vt[idx[j-3]].vld));
        check($sformatf("tput%0d.pix_out", j - 3), 32'(bus.pix_out), 32'(vt[idx[j-3]].pix));
        if (vt[idx[j-3]].vld)
          check($sformatf("tput%0d.busy_slot", j - 3), 32'(bus.busy_slot), 32'(vt[idx[j-3]].slot));
      end
      if (j < 4) begin
        bus.px = vt[idx[j]].px; bus.py = vt[idx[j]].py; bus.px_valid = 1'b1;
      end else begin
        bus.px_valid = 1'b0;
      end
      tick();
    end

    // Mid-frame writes stay in shadow until frame start.
    cfg_write(3'd0, 10'd100, 10'd50, 6'd1, 1'b0, 1'b0);
    cfg_write(3'd2, 10'd400, 10'd400, 6'd1, 1'b1, 1'b0);
    run_vec(vt[1], "prio_pre");
    run_vec(mk(405, 405, 0, 2'b00, 0, 0, 0, 0, 0), "slot2_pre");
    commit();
    run_vec(mk(110, 52, 1, 2'b01, 3, 1, 2, 2, 2), "prio_slot3");
    run_vec(mk(105, 53, 0, 2'b00, 0, 0, 0, 0, 0), "slot0_off");
    run_vec(mk(405, 405, 1, 2'b10, 2, 1, 1, 5, 5), "slot2_post");

    // Write coinciding with frame start takes effect at once and lands in shadow.
    cfg_write(3'd7, 10'd600, 10'd600, 6'd3, 1'b1, 1'b1);
    run_vec(mk(605, 600, 1, 2'b10, 7, 1, 3, 5, 0), "wr_commit");
    commit();
    run_vec(mk(605, 600, 1, 2'b10, 7, 1, 3, 5, 0), "wr_commit_shadow");

    // Reset with a hit in flight: nothing emerges and the table is cleared.
    bus.px = 10'd405; bus.py = 10'd405; bus.px_valid = 1'b1;
    tick();
    bus.px_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst.pix_valid_a", 32'(bus.pix_valid), 32'd0);
    tick();
    check("midrst.pix_valid_b", 32'(bus.pix_valid), 32'd0);
    commit();
    run_vec(mk(405, 405, 0, 2'b00, 0, 1, 0, 0, 0), "midrst_cleared");

`ifdef MOV_SPRITE_COLLISION_EN
    cfg_write(3'd1, 10'd200, 10'd200, 6'd1, 1'b1, 1'b0);
    cfg_write(3'd4, 10'd190, 10'd190, 6'd2, 1'b1, 1'b0);
    commit();
    check("coll.idle", 32'(bus.collision), 32'd0);
    run_vec(mk(205, 205, 1, 2'b10, 1, 1, 1, 5, 5), "coll_pix");
    check("coll.set", 32'(bus.collision), 32'd1);
    check("coll.mask", 32'(bus.collision_mask), 32'h12);
    commit();
    check("coll.clear", 32'(bus.collision), 32'd0);
    check("coll.mask_clear", 32'(bus.collision_mask), 32'h00);
    bus.px = 10'd205; bus.py = 10'd205; bus.px_valid = 1'b1; bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check("coll.clear_wins", 32'(bus.collision), 32'd0);
    tick();
    bus.px_valid = 1'b0;
    check("coll.reset_after", 32'(bus.collision), 32'd1);
    tick(); tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
